// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO push-side control logic and its checkers.
package fifo_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // All-ones mask covering the low sig_w bits of a data word.
    function automatic logic [15:0] width_msk(input logic [3:0] sig_w);
        width_msk = (16'd1 << sig_w) - 16'd1;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Circular priority encoder: first valid requester at or after rr_ptr.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any
);

    localparam int PW = $clog2(NUM_REQ);

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_w;
        idx    = 0;
        idx_w  = '0;
        winner = '0;
        any    = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx   = (int'(rr_ptr) + k) % NUM_REQ;
            idx_w = PW'(idx);
            if (req_valid[idx_w]) begin
                winner = idx_w;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst-locking arbiter sharing one FIFO push port between NUM_REQ producers.
module fifo_push_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int max_FIFO_WIDTH = 11,
    parameter int max_BURST      = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req_valid,
    input  logic [NUM_REQ-1:0]                       req_last,
    input  logic [NUM_REQ-1:0][max_FIFO_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                       req_ready,
    input  logic [3:0]                               sig_FIFO_WIDTH,
    input  logic [3:0]                               sig_MAX_BURST,
    input  logic                                     full,
    output logic                                     push,
    output logic [max_FIFO_WIDTH-1:0]                push_data,
    output logic [$clog2(NUM_REQ)-1:0]               grant_id,
    output logic                                     busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(max_BURST) + 1;

    arb_state_t    state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] grant_id_q, grant_id_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;

    logic [PW-1:0] pick_id;
    logic          pick_any;
    logic          in_burst;
    logic          accept;
    logic          burst_end;
    logic [3:0]    eff_burst;
    logic [PW-1:0] rr_next;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .winner    (pick_id),
        .any       (pick_any)
    );

    assign in_burst  = (state_q == BURST);
    assign eff_burst = (sig_MAX_BURST == 4'd0) ? 4'd1 : sig_MAX_BURST;
    assign accept    = in_burst && req_valid[grant_id_q] && !full;
    assign burst_end = accept && (req_last[grant_id_q] ||
                       (32'(beat_cnt_q) == 32'(eff_burst) - 32'd1));
    assign rr_next   = (grant_id_q == PW'(NUM_REQ - 1)) ? '0 : grant_id_q + PW'(1);

    assign push      = accept;
    assign push_data = in_burst ? (req_data[grant_id_q] &
                                   max_FIFO_WIDTH'(width_msk(sig_FIFO_WIDTH)))
                                : '0;
    assign grant_id  = grant_id_q;
    assign busy      = in_burst;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_id_q == PW'(gi));
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_id;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                // Owner keeps the port until burst end; a dropped valid or full just stalls.
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (burst_end) begin
                        state_d  = IDLE;
                        rr_ptr_d = rr_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed self-checking bench for fifo_push_arbiter (NUM_REQ=4, 11-bit data, burst cap 8).
module tb_fifo_push_arbiter;

    logic              clk;
    logic              rst;
    logic [3:0]        req_valid;
    logic [3:0]        req_last;
    logic [3:0][10:0]  req_data;
    logic [3:0]        req_ready;
    logic [3:0]        sig_w;
    logic [3:0]        sig_mb;
    logic              full;
    logic              push;
    logic [10:0]       push_data;
    logic [1:0]        grant_id;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    fifo_push_arbiter #(
        .NUM_REQ        (4),
        .max_FIFO_WIDTH (11),
        .max_BURST      (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .sig_FIFO_WIDTH (sig_w),
        .sig_MAX_BURST  (sig_mb),
        .full           (full),
        .push           (push),
        .push_data      (push_data),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_push"},  32'(push), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        logic [7:0] sched;
        int         beat;

        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        req_data[0] = 11'h155;
        sig_w     = 4'd11;
        sig_mb    = 4'd8;
        full      = 1'b0;
        #1;
        chk("rst_push",      32'(push), 32'd0);
        chk("rst_ready",     32'(req_ready), 32'd0);
        chk("rst_push_data", 32'(push_data), 32'd0);
        chk("rst_grant",     32'(grant_id), 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        req_data = '0;

        // Single producer 2, three beats with last on the third
        req_valid   = 4'b0100;
        req_data[2] = 11'h010;
        #1;
        chk_idle("t1_idle");
        chk("t1_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            req_data[2] = 11'(11'h010 + k);
            req_last    = (k == 2) ? 4'b0100 : 4'b0000;
            #1;
            chk("t1_push",  32'(push), 32'd1);
            chk("t1_data",  32'(push_data), 32'(32'h10 + k));
            chk("t1_grant", 32'(grant_id), 32'd2);
            chk("t1_ready", 32'(req_ready), 32'b0100);
            @(negedge clk);
        end
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("t1_end_busy", 32'(busy), 32'd0);
        chk("t1_end_push", 32'(push), 32'd0);
        chk("t1_rr_ptr",   32'(dut.rr_ptr_q), 32'd3);
        @(negedge clk);

        // Producers 0 and 1 contend with single-beat bursts
        for (int g = 0; g < 4; g++) begin
            req_valid   = 4'b0011;
            req_last    = 4'b0011;
            req_data[0] = 11'(11'h030 + g);
            req_data[1] = 11'(11'h030 + g);
            #1;
            chk_idle("t2_idle");
            @(negedge clk);
            #1;
            chk("t2_grant",   32'(grant_id), 32'(g % 2));
            chk("t2_ready",   32'(req_ready), 32'd1 << (g % 2));
            chk("t2_onehot",  32'($countones(req_ready) <= 1), 32'd1);
            chk("t2_data",    32'(push_data), 32'(32'h30 + g));
            @(negedge clk);
        end
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("t2_rr_ptr", 32'(dut.rr_ptr_q), 32'd2);
        @(negedge clk);

        // Burst cap of 2: five beats from producer 0 take three grants
        sig_mb    = 4'd2;
        req_valid = 4'b0001;
        sched     = 8'b1011_0110;
        beat      = 0;
        for (int c = 0; c < 8; c++) begin
            req_data[0] = 11'(11'h020 + beat);
            req_last[0] = (beat == 4);
            #1;
            chk("t3_push", 32'(push), 32'(sched[c]));
            if (sched[c]) begin
                chk("t3_data",  32'(push_data), 32'(32'h20 + beat));
                chk("t3_grant", 32'(grant_id), 32'd0);
                beat++;
            end
            @(negedge clk);
        end
        req_valid = '0;
        req_last  = '0;
        sig_mb    = 4'd8;
        #1;
        chk("t3_end_busy", 32'(busy), 32'd0);
        chk("t3_rr_ptr",   32'(dut.rr_ptr_q), 32'd1);
        @(negedge clk);

        // Full stall after beat 1 of 3 from producer 1
        req_valid   = 4'b0010;
        req_data[1] = 11'h040;
        #1;
        chk_idle("t4_idle");
        @(negedge clk);
        #1;
        chk("t4_b1_push", 32'(push), 32'd1);
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            full        = 1'b1;
            req_data[1] = 11'h041;
            #1;
            chk_idle("t4_stall");
            chk("t4_stall_cnt",  32'(dut.beat_cnt_q), 32'd1);
            chk("t4_stall_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        full = 1'b0;
        #1;
        chk("t4_b2_push", 32'(push), 32'd1);
        chk("t4_b2_data", 32'(push_data), 32'h41);
        @(negedge clk);
        req_data[1] = 11'h042;
        req_last    = 4'b0010;
        #1;
        chk("t4_b3_push", 32'(push), 32'd1);
        chk("t4_b3_cnt",  32'(dut.beat_cnt_q), 32'd2);
        @(negedge clk);
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("t4_end_busy", 32'(busy), 32'd0);
        chk("t4_rr_ptr",   32'(dut.rr_ptr_q), 32'd2);
        @(negedge clk);

        // Width mask at 8 bits
        sig_w       = 4'd8;
        req_valid   = 4'b0100;
        req_last    = 4'b0100;
        req_data[2] = 11'h7FF;
        #1;
        chk_idle("t5_idle");
        @(negedge clk);
        #1;
        chk("t5_push", 32'(push), 32'd1);
        chk("t5_mask", 32'(push_data), 32'h0FF);
        @(negedge clk);
        req_valid = '0;
        req_last  = '0;
        sig_w     = 4'd11;
        @(negedge clk);

        // Reset during beat 2 of 4 from producer 3, then zero burst cap acts as 1
        req_valid   = 4'b1000;
        req_data[3] = 11'h050;
        #1;
        chk_idle("t6_idle");
        @(negedge clk);
        #1;
        chk("t6_b1_push",  32'(push), 32'd1);
        chk("t6_b1_grant", 32'(grant_id), 32'd3);
        @(negedge clk);
        req_data[3] = 11'h051;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_push",  32'(push), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd0);
        chk("t6_rst_data",  32'(push_data), 32'd0);
        chk("t6_rst_grant", 32'(grant_id), 32'd0);
        chk("t6_rst_busy",  32'(busy), 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        sig_mb      = 4'd0;
        req_valid   = 4'b1001;
        req_data[0] = 11'h060;
        #1;
        chk_idle("t6_post_idle");
        @(negedge clk);
        #1;
        chk("t6_post_grant", 32'(grant_id), 32'd0);
        chk("t6_post_push",  32'(push), 32'd1);
        chk("t6_post_data",  32'(push_data), 32'h60);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("t6_cap0_busy", 32'(busy), 32'd0);
        chk("t6_cap0_rr",   32'(dut.rr_ptr_q), 32'd1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
